// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit. It runs a shift-add multiply or a restoring divide,
// one bit per cycle. While it runs it stalls execute, then returns the result
// as a single-cycle done pulse.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            muldiv_start_e,
    input  logic [2:0]      muldiv_op_e,
    input  logic [XLEN-1:0] muldiv_data1_e,
    input  logic [XLEN-1:0] muldiv_data2_e,
    input  logic            muldiv_flush,
    output logic            muldiv_stall_e,
    output logic            muldiv_done,
    output logic [XLEN-1:0] muldiv_out,
    output logic            muldiv_busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic              neg_reg;        // result needs two's-complement fix-up
    logic [XLEN-1:0]   b_reg;          // multiplicand / divisor magnitude
    logic [XLEN-1:0]   acc_hi_reg;     // product high word / partial remainder
    logic [XLEN-1:0]   acc_lo_reg;     // multiplier bits / dividend-quotient bits
    logic [CW-1:0]     cnt_reg;
    logic              done_reg;
    logic [XLEN-1:0]   out_reg;
    logic              busy_reg;

    // Operand decode, used only while IDLE
    logic              signed_a, signed_b, a_neg, b_neg, neg_start;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special, accept, last_iter;
    logic [XLEN-1:0]   special_result;

    // Iteration datapath and final fix-up
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   divres_raw, divres_fix, fix_result;

    // Signedness per op: MULH/DIV/REM sign both, MULHSU signs rs1 only
    always_comb begin
        signed_a  = (muldiv_op_e == 3'd1) || (muldiv_op_e == 3'd2) ||
                    (muldiv_op_e == 3'd4) || (muldiv_op_e == 3'd6);
        signed_b  = (muldiv_op_e == 3'd1) || (muldiv_op_e == 3'd4) ||
                    (muldiv_op_e == 3'd6);
        a_neg     = signed_a & muldiv_data1_e[XLEN-1];
        b_neg     = signed_b & muldiv_data2_e[XLEN-1];
        a_mag     = a_neg ? (~muldiv_data1_e + 1'b1) : muldiv_data1_e;
        b_mag     = b_neg ? (~muldiv_data2_e + 1'b1) : muldiv_data2_e;
        // remainder takes the dividend sign; everything else is sign(a)^sign(b)
        neg_start = (muldiv_op_e[2] & muldiv_op_e[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero  = muldiv_op_e[2] && (muldiv_data2_e == '0);
        div_ovf   = muldiv_op_e[2] && !muldiv_op_e[0] &&
                    (muldiv_data1_e == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (&muldiv_data2_e);
        special   = div_zero | div_ovf;
        if (div_zero)
            special_result = muldiv_op_e[1] ? muldiv_data1_e : {XLEN{1'b1}};
        else
            special_result = muldiv_op_e[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        accept    = (state_reg == S_IDLE) & muldiv_start_e & ~muldiv_flush;
        last_iter = (cnt_reg == CW'(XLEN-1));
    end

    // One multiply or divide step, plus the sign fix-up of the final result
    always_comb begin
        mul_sum    = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, b_reg} : '0);
        div_shift  = {acc_hi_reg, acc_lo_reg[XLEN-1]};
        div_ge     = (div_shift >= {1'b0, b_reg});
        // partial remainder stays below the divisor, so XLEN bits suffice
        div_diff   = div_shift[XLEN-1:0] - b_reg;
        prod_fix   = neg_reg ? (~{acc_hi_reg, acc_lo_reg} + 1'b1)
                             : {acc_hi_reg, acc_lo_reg};
        divres_raw = op_reg[1] ? acc_hi_reg : acc_lo_reg;
        divres_fix = neg_reg ? (~divres_raw + 1'b1) : divres_raw;
        case (op_reg)
            3'd0:                fix_result = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_result = prod_fix[2*XLEN-1:XLEN];
            default:             fix_result = divres_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic and the combinational stall
    always_comb begin
        state_next     = state_reg;
        muldiv_stall_e = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    muldiv_stall_e = 1'b1;
                    if (special)
                        state_next = S_DONE;
                    else
                        state_next = muldiv_op_e[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                muldiv_stall_e = ~muldiv_flush;
                if (muldiv_flush)
                    state_next = S_IDLE;
                else if (last_iter)
                    state_next = S_FIX;
            end
            S_FIX: begin
                muldiv_stall_e = ~muldiv_flush;
                state_next     = muldiv_flush ? S_IDLE : S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            b_reg      <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
            out_reg    <= '0;
            busy_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            out_reg  <= '0;
            busy_reg <= (state_next != S_IDLE);
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg     <= muldiv_op_e;
                        neg_reg    <= neg_start;
                        b_reg      <= b_mag;
                        acc_hi_reg <= '0;
                        acc_lo_reg <= a_mag;
                        cnt_reg    <= '0;
                        if (special) begin
                            done_reg <= 1'b1;
                            out_reg  <= special_result;
                        end
                    end
                end
                S_MUL: begin
                    if (!muldiv_flush) begin
                        acc_hi_reg <= mul_sum[XLEN:1];
                        acc_lo_reg <= {mul_sum[0], acc_lo_reg[XLEN-1:1]};
                        cnt_reg    <= last_iter ? '0 : cnt_reg + 1'b1;
                    end
                end
                S_DIV: begin
                    if (!muldiv_flush) begin
                        acc_hi_reg <= div_ge ? div_diff : div_shift[XLEN-1:0];
                        acc_lo_reg <= {acc_lo_reg[XLEN-2:0], div_ge};
                        cnt_reg    <= last_iter ? '0 : cnt_reg + 1'b1;
                    end
                end
                S_FIX: begin
                    if (!muldiv_flush) begin
                        done_reg <= 1'b1;
                        out_reg  <= fix_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign muldiv_done = done_reg;
    assign muldiv_out  = out_reg;
    assign muldiv_busy = busy_reg;

endmodule
